// File: rtl/mc_seq_pkg.sv
// Shared types and constants for the multi-cycle sequencer.
package mc_seq_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_FWAIT  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_MWAIT  = 3'd5,
    S_WB     = 3'd6,
    S_HALT   = 3'd7
  } state_e;

  localparam logic [1:0] HC_NONE    = 2'b00;
  localparam logic [1:0] HC_ILLEGAL = 2'b01;
  localparam logic [1:0] HC_IMEM_TO = 2'b10;
  localparam logic [1:0] HC_DMEM_TO = 2'b11;

  localparam int TIMEOUT_CYC_DEF = 16;

endpackage

// File: rtl/mc_seq_timeout.sv
// Wait-cycle counter shared by the fetch and data memory handshakes.
// expired flags the cycle whose wait would bring the count to limit.
module mc_seq_timeout #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic             expired
);

  logic [CNT_W-1:0] cnt;

  // Count waiting cycles; clear wins so a new state always starts from 0.
  always_ff @(posedge clk) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + 1'b1;
  end

  assign expired = (cnt == limit - 1'b1);

endmodule

// File: rtl/mc_seq_ctrl.sv
// Multi-cycle sequencer: fetch/decode/exec/mem/wb ordering, memory
// handshakes, IR/PC/RF strobes and sticky halt.
// Optional MC_SEQ_PERF_EN adds cycle and retired-instruction counters.
module mc_seq_ctrl
  import mc_seq_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int CNT_W       = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  output logic        dmem_req_valid,
  output logic        dmem_req_we,
  input  logic        dmem_req_ready,
  input  logic        dmem_rsp_valid,
  input  logic        dec_mem_read,
  input  logic        dec_mem_write,
  input  logic        dec_reg_write,
  input  logic        dec_illegal,
  output logic        ir_we,
  output logic        pc_we,
  output logic        rf_we,
  output logic [2:0]  state_o,
  output logic        halt,
`ifdef MC_SEQ_PERF_EN
  output logic [63:0] perf_cycle,
  output logic [63:0] perf_instret,
`endif
  output logic [1:0]  halt_cause
);

  state_e     state, state_nxt;
  logic [1:0] cause_nxt;
  logic       to_en, to_exp;

  mc_seq_timeout #(.CNT_W(CNT_W)) u_to (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (state_nxt != state),
    .en      (to_en),
    .limit   (CNT_W'(TIMEOUT_CYC)),
    .expired (to_exp)
  );

  // State register; reset abandons any in-flight memory transaction.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_nxt;
  end

  // Halt cause is captured only on the transition into HALT.
  always_ff @(posedge clk) begin
    if (!rst_n)                                   halt_cause <= HC_NONE;
    else if (state != S_HALT && state_nxt == S_HALT) halt_cause <= cause_nxt;
  end

  // Next-state, handshake valids and strobes, all decoded from state.
  always_comb begin
    state_nxt      = state;
    cause_nxt      = HC_NONE;
    imem_req_valid = 1'b0;
    dmem_req_valid = 1'b0;
    dmem_req_we    = 1'b0;
    ir_we          = 1'b0;
    pc_we          = 1'b0;
    rf_we          = 1'b0;
    to_en          = 1'b0;
    case (state)
      S_FETCH: begin
        imem_req_valid = 1'b1;
        if (imem_req_ready) state_nxt = S_FWAIT;
        else begin
          to_en = 1'b1;
          if (to_exp) begin state_nxt = S_HALT; cause_nxt = HC_IMEM_TO; end
        end
      end
      S_FWAIT: begin
        if (imem_rsp_valid) begin
          ir_we     = 1'b1;
          state_nxt = S_DECODE;
        end else begin
          to_en = 1'b1;
          if (to_exp) begin state_nxt = S_HALT; cause_nxt = HC_IMEM_TO; end
        end
      end
      S_DECODE: begin
        if (dec_illegal) begin state_nxt = S_HALT; cause_nxt = HC_ILLEGAL; end
        else state_nxt = S_EXEC;
      end
      S_EXEC: state_nxt = (dec_mem_read || dec_mem_write) ? S_MEM : S_WB;
      S_MEM: begin
        dmem_req_valid = 1'b1;
        dmem_req_we    = dec_mem_write;
        if (dmem_req_ready) state_nxt = S_MWAIT;
        else begin
          to_en = 1'b1;
          if (to_exp) begin state_nxt = S_HALT; cause_nxt = HC_DMEM_TO; end
        end
      end
      S_MWAIT: begin
        if (dmem_rsp_valid) state_nxt = S_WB;
        else begin
          to_en = 1'b1;
          if (to_exp) begin state_nxt = S_HALT; cause_nxt = HC_DMEM_TO; end
        end
      end
      S_WB: begin
        pc_we     = 1'b1;
        rf_we     = dec_reg_write;
        state_nxt = S_FETCH;
      end
      default: ;
    endcase
  end

  assign state_o = state;
  assign halt    = (state == S_HALT);

`ifdef MC_SEQ_PERF_EN
  // Performance counters; both freeze once halted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_cycle   <= '0;
      perf_instret <= '0;
    end else if (state != S_HALT) begin
      perf_cycle <= perf_cycle + 64'd1;
      if (state == S_WB) perf_instret <= perf_instret + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mc_seq_ctrl.sv
// Directed bench for mc_seq_ctrl: inputs driven at negedge, outputs
// sampled 1ns later, expected values written by hand.
module tb_mc_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic       dmem_req_valid, dmem_req_we, dmem_req_ready, dmem_rsp_valid;
  logic       dec_mem_read, dec_mem_write, dec_reg_write, dec_illegal;
  logic       ir_we, pc_we, rf_we, halt;
  logic [2:0] state_o;
  logic [1:0] halt_cause;
`ifdef MC_SEQ_PERF_EN
  logic [63:0] perf_cycle, perf_instret;
`endif

  int checks = 0, failures = 0;
  int rf_cnt = 0, pc_cnt = 0, ir_cnt = 0;
  int n;

  always #5 clk = ~clk;

  mc_seq_ctrl #(.TIMEOUT_CYC(16), .CNT_W(5)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .dmem_req_valid (dmem_req_valid),
    .dmem_req_we    (dmem_req_we),
    .dmem_req_ready (dmem_req_ready),
    .dmem_rsp_valid (dmem_rsp_valid),
    .dec_mem_read   (dec_mem_read),
    .dec_mem_write  (dec_mem_write),
    .dec_reg_write  (dec_reg_write),
    .dec_illegal    (dec_illegal),
    .ir_we          (ir_we),
    .pc_we          (pc_we),
    .rf_we          (rf_we),
    .state_o        (state_o),
    .halt           (halt),
`ifdef MC_SEQ_PERF_EN
    .perf_cycle     (perf_cycle),
    .perf_instret   (perf_instret),
`endif
    .halt_cause     (halt_cause)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic smp();
    #1;
    rf_cnt += int'(rf_we);
    pc_cnt += int'(pc_we);
    ir_cnt += int'(ir_we);
  endtask

  task automatic idle();
    imem_req_ready = 0; imem_rsp_valid = 0;
    dmem_req_ready = 0; dmem_rsp_valid = 0;
  endtask

  task automatic do_reset();
    cyc(); idle(); rst_n = 0; smp();
    cyc(); rst_n = 1; smp();
    chk("rst_state", 64'(state_o), 64'd0);
    chk("rst_halt", 64'(halt), 64'd0);
    chk("rst_cause", 64'(halt_cause), 64'd0);
    rf_cnt = 0; pc_cnt = 0; ir_cnt = 0;
  endtask

  task automatic set_dec(input logic mr, input logic mw, input logic rw, input logic il);
    dec_mem_read = mr; dec_mem_write = mw; dec_reg_write = rw; dec_illegal = il;
  endtask

  // FETCH (accepted at once), FWAIT (response next cycle), then DECODE sample.
  task automatic fetch_decode();
    cyc(); imem_req_ready = 1; smp();
    chk("fetch_state", 64'(state_o), 64'd0);
    chk("fetch_valid", 64'(imem_req_valid), 64'd1);
    cyc(); imem_req_ready = 0; imem_rsp_valid = 1; smp();
    chk("fwait_state", 64'(state_o), 64'd1);
    chk("fwait_ir_we", 64'(ir_we), 64'd1);
    cyc(); imem_rsp_valid = 0; smp();
    chk("decode_state", 64'(state_o), 64'd2);
    chk("decode_ir_we", 64'(ir_we), 64'd0);
  endtask

  initial begin
    rst_n = 0; idle(); set_dec(0, 0, 0, 0);
    cyc(); cyc(); smp();
    chk("reset_state", 64'(state_o), 64'd0);
    chk("reset_halt", 64'(halt), 64'd0);
    chk("reset_cause", 64'(halt_cause), 64'd0);
    chk("reset_strobes", 64'({ir_we, pc_we, rf_we, dmem_req_valid}), 64'd0);
    do_reset();

    // R-type add: 0,1,2,3,6,0 with ir_we in cycle 2, pc_we/rf_we in cycle 5.
    set_dec(0, 0, 1, 0);
    fetch_decode();
    cyc(); smp(); chk("alu_exec", 64'(state_o), 64'd3);
    cyc(); smp(); chk("alu_wb", 64'(state_o), 64'd6);
    chk("alu_pc_we", 64'(pc_we), 64'd1);
    chk("alu_rf_we", 64'(rf_we), 64'd1);
    cyc(); smp(); chk("alu_next", 64'(state_o), 64'd0);
    chk("alu_counts", 64'({rf_cnt[7:0], pc_cnt[7:0], ir_cnt[7:0]}), 64'h010101);

    // Load: MEM held 3 cycles, response 2 cycles after acceptance.
    rf_cnt = 0; pc_cnt = 0;
    set_dec(1, 0, 1, 0);
    fetch_decode();
    cyc(); smp(); chk("ld_exec", 64'(state_o), 64'd3);
    for (int i = 0; i < 3; i++) begin
      cyc(); dmem_req_ready = (i == 2); smp();
      chk("ld_mem", 64'({state_o, dmem_req_valid, dmem_req_we}), 64'({3'd4, 1'b1, 1'b0}));
    end
    for (int i = 0; i < 3; i++) begin
      cyc(); dmem_req_ready = 0; dmem_rsp_valid = (i == 2); smp();
      chk("ld_mwait", 64'(state_o), 64'd5);
    end
    cyc(); dmem_rsp_valid = 0; smp();
    chk("ld_wb", 64'(state_o), 64'd6);
    chk("ld_rf_we", 64'(rf_we), 64'd1);
    cyc(); smp(); chk("ld_next", 64'(state_o), 64'd0);
    chk("ld_rf_once", 64'(rf_cnt), 64'd1);

    // Store: we=1 on the request, no register write in WB.
    rf_cnt = 0;
    set_dec(0, 1, 0, 0);
    fetch_decode();
    cyc(); smp(); chk("st_exec", 64'(state_o), 64'd3);
    cyc(); dmem_req_ready = 1; smp();
    chk("st_mem", 64'({state_o, dmem_req_valid, dmem_req_we}), 64'({3'd4, 1'b1, 1'b1}));
    cyc(); dmem_req_ready = 0; dmem_rsp_valid = 1; smp();
    chk("st_mwait", 64'(state_o), 64'd5);
    cyc(); dmem_rsp_valid = 0; smp();
    chk("st_wb", 64'({state_o, pc_we, rf_we}), 64'({3'd6, 1'b1, 1'b0}));
    chk("st_rf_cnt", 64'(rf_cnt), 64'd0);

    // Illegal opcode: HALT after DECODE, cause 01, sticky, no strobes.
    cyc(); idle(); smp();
    rf_cnt = 0; pc_cnt = 0; ir_cnt = 0;
    set_dec(0, 0, 1, 1);
    fetch_decode();
    ir_cnt = 0;
    cyc(); smp();
    chk("ill_halt", 64'({state_o, halt, halt_cause}), 64'({3'd7, 1'b1, 2'b01}));
    for (int i = 0; i < 4; i++) begin
      cyc(); imem_req_ready = 1; imem_rsp_valid = 1; dmem_req_ready = 1; dmem_rsp_valid = 1; smp();
      chk("ill_sticky", 64'({state_o, imem_req_valid, dmem_req_valid}), 64'({3'd7, 1'b0, 1'b0}));
    end
    chk("ill_no_strobe", 64'({rf_cnt[7:0], pc_cnt[7:0], ir_cnt[7:0]}), 64'd0);
    set_dec(0, 0, 1, 0);
    do_reset();

    // Fetch-side timeout: 16 FWAIT cycles then HALT with cause 10.
    cyc(); imem_req_ready = 1; smp();
    n = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(); imem_req_ready = 0; smp();
      n += int'(state_o == 3'd1);
    end
    chk("ito_fwait_cycles", 64'(n), 64'd16);
    cyc(); smp();
    chk("ito_halt", 64'({state_o, halt_cause}), 64'({3'd7, 2'b10}));
    do_reset();

    // Data-side timeout: 16 MEM cycles then HALT with cause 11.
    set_dec(1, 0, 1, 0);
    fetch_decode();
    cyc(); smp();
    n = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(); smp();
      n += int'(state_o == 3'd4);
    end
    chk("dto_mem_cycles", 64'(n), 64'd16);
    cyc(); smp();
    chk("dto_halt", 64'({state_o, halt_cause}), 64'({3'd7, 2'b11}));
    do_reset();

    // Reset while in MWAIT: back to FETCH, late response ignored.
    fetch_decode();
    cyc(); smp();
    cyc(); dmem_req_ready = 1; smp();
    cyc(); dmem_req_ready = 0; smp();
    chk("rmw_mwait", 64'(state_o), 64'd5);
    cyc(); rst_n = 0; smp();
    cyc(); rst_n = 1; smp();
    chk("rmw_fetch", 64'({state_o, halt}), 64'({3'd0, 1'b0}));
    rf_cnt = 0;
    cyc(); dmem_rsp_valid = 1; smp();
    cyc(); dmem_rsp_valid = 0; smp();
    chk("rmw_state", 64'(state_o), 64'd0);
    chk("rmw_no_rf", 64'(rf_cnt), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
